// File: rtl/end_screen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : end_screen_pkg
// Desc     : Shared geometry constants and fade FSM state type for the
//            end-of-game screen renderer.
// Revision : 1.0 - initial release
// ============================================================================
package end_screen_pkg;

    localparam int IMG_W  = 320;
    localparam int IMG_H  = 240;
    localparam int ADDR_W = 17;
    localparam int SCR_W  = 640;
    localparam int SCR_H  = 480;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        HOLD     = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

endpackage
`default_nettype wire

// File: rtl/end_screen_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : end_screen_fade_ctrl
// Desc     : Frame-tick detection, per-step frame counter and fade FSM that
//            produce the end-screen opacity level. Built only when
//            END_SCREEN_FADE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef END_SCREEN_FADE_EN
module end_screen_fade_ctrl
    import end_screen_pkg::*;
#(
    parameter int unsigned FADE_FRAMES = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       vs,
    input  logic       show_end,
    output logic [3:0] fade_level,
    output logic       end_active
);

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_FADE_IN  = FADE_IN;
    localparam logic [1:0] S_HOLD     = HOLD;
    localparam logic [1:0] S_FADE_OUT = FADE_OUT;
    localparam logic [7:0] c_LAST_STEP = 8'(FADE_FRAMES - 1);

    logic       vs_prev_q;
    logic       w_tick;
    logic       w_step;
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] level_q, level_d;

    assign w_tick = vs_prev_q & ~vs;
    assign w_step = w_tick && (cnt_q == c_LAST_STEP);

    // A show_end change is checked before stepping so it wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (w_tick) begin
            cnt_d = (cnt_q == c_LAST_STEP) ? 8'd0 : cnt_q + 8'd1;
        end
        case (state_q)
            S_IDLE: begin
                level_d = 4'h0;
                cnt_d   = 8'd0;
                if (show_end) begin
                    state_d = S_FADE_IN;
                end
            end
            S_FADE_IN: begin
                if (!show_end) begin
                    state_d = S_FADE_OUT;
                    cnt_d   = 8'd0;
                end else if (level_q == 4'hF) begin
                    state_d = S_HOLD;
                    cnt_d   = 8'd0;
                end else if (w_step) begin
                    level_d = level_q + 4'h1;
                    if (level_q == 4'hE) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                level_d = 4'hF;
                cnt_d   = 8'd0;
                if (!show_end) begin
                    state_d = S_FADE_OUT;
                end
            end
            S_FADE_OUT: begin
                if (show_end) begin
                    state_d = S_FADE_IN;
                    cnt_d   = 8'd0;
                end else if (level_q == 4'h0) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else if (w_step) begin
                    level_d = level_q - 4'h1;
                    if (level_q == 4'h1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                level_d = 4'h0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_prev_q <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            level_q   <= 4'h0;
        end else begin
            vs_prev_q <= vs;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
        end
    end

    assign fade_level = level_q;
    assign end_active = (state_q != S_IDLE);

endmodule
`endif
`default_nettype wire

// File: rtl/end_screen_renderer.sv
`default_nettype none
// ============================================================================
// Module   : end_screen_renderer
// Desc     : Maps DrawX/DrawY onto a 2x-scaled 320x240 index ROM, re-times the
//            ROM data into a palette index and supplies the fade level.
//            END_SCREEN_FADE_EN selects the frame-timed fade FSM; otherwise
//            the level simply follows show_end.
// Revision : 1.0 - initial release
// ============================================================================
module end_screen_renderer
    import end_screen_pkg::*;
#(
    parameter int unsigned FADE_FRAMES = 4,
    parameter logic [3:0]  BLACK_INDEX = 4'h8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank_n,
    input  logic              vs,
    input  logic              show_end,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        index_out,
    output logic              pix_valid,
    output logic [3:0]        fade_level,
    output logic              end_active
);

    logic [ADDR_W-1:0] w_x;
    logic [ADDR_W-1:0] w_y;
    logic              w_in_win;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              win1_q;
    logic              win2_q;
    logic [3:0]        index_q, index_d;
    logic              valid_q;

    // y*320 as y*256 + y*64 keeps the address path multiplier-free.
    assign w_x        = ADDR_W'(DrawX >> 1);
    assign w_y        = ADDR_W'(DrawY >> 1);
    assign w_in_win   = (DrawX < 10'(SCR_W)) && (DrawY < 10'(SCR_H)) && blank_n;
    assign rom_addr_d = w_in_win ? ((w_y << 8) + (w_y << 6) + w_x) : '0;
    assign index_d    = win2_q ? rom_q : BLACK_INDEX;

    // win1/win2 track the in-window flag through the address and ROM stages.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q <= '0;
            win1_q     <= 1'b0;
            win2_q     <= 1'b0;
            index_q    <= BLACK_INDEX;
            valid_q    <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            win1_q     <= w_in_win;
            win2_q     <= win1_q;
            index_q    <= index_d;
            valid_q    <= win2_q;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign index_out = index_q;
    assign pix_valid = valid_q;

`ifdef END_SCREEN_FADE_EN
    end_screen_fade_ctrl #(
        .FADE_FRAMES (FADE_FRAMES)
    ) u_fade_ctrl (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .vs         (vs),
        .show_end   (show_end),
        .fade_level (fade_level),
        .end_active (end_active)
    );
`else
    localparam int unsigned c_UNUSED_FADE_FRAMES = FADE_FRAMES;

    logic       w_unused_vs;
    logic [3:0] fade_q;
    logic       active_q;

    assign w_unused_vs = vs;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fade_q   <= 4'h0;
            active_q <= 1'b0;
        end else begin
            fade_q   <= show_end ? 4'hF : 4'h0;
            active_q <= show_end;
        end
    end

    assign fade_level = fade_q;
    assign end_active = active_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_end_screen_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_end_screen_renderer
// Desc     : Self-checking bench for end_screen_renderer with a synchronous
//            ROM model returning addr[3:0] and queued expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_end_screen_renderer;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank_n, vs, show_end;
    logic [16:0] rom_addr;
    logic [3:0]  rom_q, index_out, fade_level;
    logic        pix_valid, end_active;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0] idx;
        logic       valid;
    } pix_exp_t;

    pix_exp_t pq[$];
    int       lq[$];

    int tab_x[0:9] = '{3, 639, 700, 100, 0, 639, 640, 1, 2, 319};
    int tab_y[0:9] = '{5, 479, 5, 100, 0, 480, 0, 1, 2, 239};
    int tab_b[0:9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_q <= rom_addr[3:0];

    end_screen_renderer #(
        .FADE_FRAMES (4),
        .BLACK_INDEX (4'h8)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank_n    (blank_n),
        .vs         (vs),
        .show_end   (show_end),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .index_out  (index_out),
        .pix_valid  (pix_valid),
        .fade_level (fade_level),
        .end_active (end_active)
    );

    task automatic do_reset();
        @(negedge Clk);
        Reset_n  = 1'b0;
        show_end = 1'b0;
        vs       = 1'b1;
        blank_n  = 1'b0;
        DrawX    = 10'd0;
        DrawY    = 10'd0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic frame_tick();
        @(negedge Clk);
        vs = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        vs = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_n  = 1'b0;
        DrawX    = 10'd3;
        DrawY    = 10'd5;
        blank_n  = 1'b1;
        vs       = 1'b1;
        show_end = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        vectors++;
        if (rom_addr !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_rom_addr got %0d want 0", rom_addr);
        end
        vectors++;
        if (index_out !== 4'h8) begin
            miscompares++;
            $display("FAIL reset_index got %h want 8", index_out);
        end
        vectors++;
        if (pix_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pix_valid got %b want 0", pix_valid);
        end
        vectors++;
        if (fade_level !== 4'h0 || end_active !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fade got level=%0d active=%b want 0/0", fade_level, end_active);
        end
        do_reset();
    endtask

    task automatic test_pixel_path();
        int x, y, b;
        logic win;
        logic [16:0] ea;
        pix_exp_t e;
        pq.delete();
        for (int i = 0; i < 30; i++) begin
            if (i < 10) begin
                x = tab_x[i]; y = tab_y[i]; b = tab_b[i];
            end else if (i < 28) begin
                x = $urandom_range(0, 799);
                y = $urandom_range(0, 524);
                b = $urandom_range(0, 1);
            end else begin
                x = 0; y = 0; b = 0;
            end
            @(negedge Clk);
            DrawX   = 10'(x);
            DrawY   = 10'(y);
            blank_n = b[0];
            win = (x < 640) && (y < 480) && (b != 0);
            ea  = win ? 17'((y / 2) * 320 + (x / 2)) : 17'd0;
            pq.push_back('{win ? ea[3:0] : 4'h8, win});
            @(posedge Clk);
            #1;
            vectors++;
            if (rom_addr !== ea) begin
                miscompares++;
                $display("FAIL rom_addr x=%0d y=%0d b=%0d got %0d want %0d", x, y, b, rom_addr, ea);
            end
            if (pq.size() > 2) begin
                e = pq.pop_front();
                vectors++;
                if (index_out !== e.idx || pix_valid !== e.valid) begin
                    miscompares++;
                    $display("FAIL pixel_out step=%0d got idx=%h valid=%b want idx=%h valid=%b",
                             i, index_out, pix_valid, e.idx, e.valid);
                end
            end
        end
        pq.delete();
    endtask

`ifdef END_SCREEN_FADE_EN
    task automatic test_fade_in();
        int e;
        do_reset();
        @(negedge Clk);
        show_end = 1'b1;
        @(posedge Clk);
        #1;
        vectors++;
        if (end_active !== 1'b1 || fade_level !== 4'h0) begin
            miscompares++;
            $display("FAIL fade_start got level=%0d active=%b want 0/1", fade_level, end_active);
        end
        for (int t = 1; t <= 64; t++) begin
            frame_tick();
            lq.push_back((t / 4 > 15) ? 15 : t / 4);
            e = lq.pop_front();
            vectors++;
            if (fade_level !== 4'(e) || end_active !== 1'b1) begin
                miscompares++;
                $display("FAIL fade_in tick=%0d got level=%0d active=%b want %0d/1",
                         t, fade_level, end_active, e);
            end
        end
        @(negedge Clk);
        show_end = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            frame_tick();
        end
        vectors++;
        if (fade_level !== 4'd14) begin
            miscompares++;
            $display("FAIL hold_to_out got level=%0d want 14", fade_level);
        end
    endtask

    task automatic test_reversal();
        int e;
        do_reset();
        @(negedge Clk);
        show_end = 1'b1;
        for (int t = 1; t <= 28; t++) begin
            frame_tick();
        end
        vectors++;
        if (fade_level !== 4'd7) begin
            miscompares++;
            $display("FAIL reversal_peak got level=%0d want 7", fade_level);
        end
        @(negedge Clk);
        show_end = 1'b0;
        @(posedge Clk);
        #1;
        vectors++;
        if (fade_level !== 4'd7 || end_active !== 1'b1) begin
            miscompares++;
            $display("FAIL reversal_turn got level=%0d active=%b want 7/1", fade_level, end_active);
        end
        for (int t = 1; t <= 28; t++) begin
            frame_tick();
            lq.push_back(7 - t / 4);
            e = lq.pop_front();
            vectors++;
            if (fade_level !== 4'(e) || end_active !== (e != 0)) begin
                miscompares++;
                $display("FAIL fade_out tick=%0d got level=%0d active=%b want %0d/%0d",
                         t, fade_level, end_active, e, e != 0);
            end
        end
    endtask

    task automatic test_coincident();
        int e;
        do_reset();
        @(negedge Clk);
        show_end = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            frame_tick();
        end
        @(negedge Clk);
        show_end = 1'b0;
        vs       = 1'b0;
        @(posedge Clk);
        #1;
        vectors++;
        if (fade_level !== 4'd1 || end_active !== 1'b1) begin
            miscompares++;
            $display("FAIL coincident got level=%0d active=%b want 1/1", fade_level, end_active);
        end
        @(negedge Clk);
        vs = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            frame_tick();
            lq.push_back((t < 4) ? 1 : 0);
            e = lq.pop_front();
            vectors++;
            if (fade_level !== 4'(e) || end_active !== (e != 0)) begin
                miscompares++;
                $display("FAIL coincident_after tick=%0d got level=%0d active=%b want %0d",
                         t, fade_level, end_active, e);
            end
        end
    endtask

    task automatic test_reset_mid_fade();
        do_reset();
        @(negedge Clk);
        show_end = 1'b1;
        DrawX    = 10'd3;
        DrawY    = 10'd5;
        blank_n  = 1'b1;
        for (int t = 1; t <= 36; t++) begin
            frame_tick();
        end
        vectors++;
        if (fade_level !== 4'd9 || index_out !== 4'h1 || pix_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset got level=%0d idx=%h valid=%b want 9/1/1",
                     fade_level, index_out, pix_valid);
        end
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        vectors++;
        if (fade_level !== 4'h0 || end_active !== 1'b0 || index_out !== 4'h8 ||
            pix_valid !== 1'b0 || rom_addr !== 17'd0) begin
            miscompares++;
            $display("FAIL async_reset got level=%0d active=%b idx=%h valid=%b addr=%0d want 0/0/8/0/0",
                     fade_level, end_active, index_out, pix_valid, rom_addr);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        vectors++;
        if (fade_level !== 4'h0 || end_active !== 1'b1) begin
            miscompares++;
            $display("FAIL restart got level=%0d active=%b want 0/1", fade_level, end_active);
        end
        repeat (2) @(posedge Clk);
        #1;
        vectors++;
        if (index_out !== 4'h1 || pix_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL refill got idx=%h valid=%b want 1/1", index_out, pix_valid);
        end
        for (int t = 1; t <= 4; t++) begin
            frame_tick();
        end
        vectors++;
        if (fade_level !== 4'd1) begin
            miscompares++;
            $display("FAIL restart_step got level=%0d want 1", fade_level);
        end
    endtask
`else
    task automatic test_level_mode();
        int e;
        do_reset();
        @(negedge Clk);
        show_end = 1'b1;
        #1;
        vectors++;
        if (fade_level !== 4'h0 || end_active !== 1'b0) begin
            miscompares++;
            $display("FAIL level_latency got level=%0d active=%b want 0/0", fade_level, end_active);
        end
        for (int t = 1; t <= 3; t++) begin
            frame_tick();
            lq.push_back(15);
            e = lq.pop_front();
            vectors++;
            if (fade_level !== 4'(e) || end_active !== 1'b1) begin
                miscompares++;
                $display("FAIL level_on tick=%0d got level=%0d active=%b want %0d/1",
                         t, fade_level, end_active, e);
            end
        end
        @(negedge Clk);
        show_end = 1'b0;
        @(posedge Clk);
        #1;
        vectors++;
        if (fade_level !== 4'h0 || end_active !== 1'b0) begin
            miscompares++;
            $display("FAIL level_off got level=%0d active=%b want 0/0", fade_level, end_active);
        end
        @(negedge Clk);
        show_end = 1'b1;
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        vectors++;
        if (fade_level !== 4'h0 || end_active !== 1'b0) begin
            miscompares++;
            $display("FAIL level_reset got level=%0d active=%b want 0/0", fade_level, end_active);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        vectors++;
        if (fade_level !== 4'hF || end_active !== 1'b1) begin
            miscompares++;
            $display("FAIL level_release got level=%0d active=%b want 15/1", fade_level, end_active);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pixel_path();
`ifdef END_SCREEN_FADE_EN
        test_fade_in();
        test_reversal();
        test_coincident();
        test_reset_mid_fade();
`else
        test_level_mode();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
